aes_shiftrows_byte_buffer: RTL and testbench
============================================

// Module: aes_shiftrows_byte_buffer
// PURPOSE
//  Byte-serial ShiftRows/InvShiftRows stage for the 8-bit-datapath AES-128 core.
//  - Accepts 16 state bytes in column-major order (index i = 4*col + row).
//  - Emits the same 16 bytes permuted per ShiftRows (or InvShiftRows).
//  - Sits directly upstream of the byte-lane select mux feeding SubBytes/MixColumns.
//  - Ping-pong buffered: sustains one byte/cycle in and out once primed.
// PARAMETERS
//  DATA_W    8  byte width; only 8 is supported
//  NUM_BYTES 16 bytes per AES state; fixed at 16
//  INVERSE   0  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
// PORTS
//  clk       in   1   single clock; all logic on rising edge
//  rst_n     in   1   synchronous active-low reset
//  flush     in   1   synchronous abort; clears all buffered state
//  shift_en  in   1   1 = permute block, 0 = pass through in order; sampled with the block's byte 0
//  in_valid  in   1   input byte valid
//  in_ready  out  1   input byte accepted when in_valid & in_ready
//  in_data   in   8   input state byte, column-major order
//  out_valid out  1   output byte valid
//  out_ready in   1   output byte consumed when out_valid & out_ready
//  out_data  out  8   permuted state byte
//  out_idx   out  4   output position k (0..15, column-major) of out_data
//  out_last  out  1   high with out_valid when out_idx == 15
// BEHAVIOUR
//  Reset (rst_n = 0 at a clock edge)
//   - Clears wr_bank, rd_bank, wr_idx, rd_idx, full[1:0] and mode[1:0].
//   - After reset: in_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
//   - Bank contents are not reset.
//  Write side
//   - in_ready = ~full[wr_bank].
//   - On accept: bank[wr_bank][wr_idx] <= in_data, then wr_idx++.
//   - When wr_idx == 0 at accept: mode[wr_bank] <= shift_en.
//   - On accept at wr_idx == 15: wr_idx <= 0, full[wr_bank] <= 1, wr_bank toggles.
//  Read side
//   - out_valid = full[rd_bank]; out_idx = rd_idx; k = rd_idx; r = k[1:0]; c = k[3:2].
//   - Source address when mode = 1:
//     - INVERSE = 0: 4*((c + r) mod 4) + r
//     - INVERSE = 1: 4*((c - r) mod 4) + r
//   - Source address when mode = 0: k.
//   - out_data is combinational from bank[rd_bank][src]; forced to 0 when out_valid = 0.
//   - On consume: rd_idx++. At rd_idx == 15: rd_idx <= 0, full[rd_bank] <= 0, rd_bank toggles.
//  Latency and throughput
//   - First out_valid comes 1 cycle after the 16th byte of a block is accepted.
//   - Full throughput: 16 bytes per 16 cycles, sustained.
//  Boundary conditions
//   - Same-cycle write to one bank and read from the other is always legal.
//   - Both banks full: in_ready = 0 until the read bank drains.
//   - In-order delivery: rd_bank always points at the oldest full bank.
//   - If the write completing one bank and the read freeing the other land in the same cycle, both updates apply.
//   - flush = 1: same effect as reset, except on flags only (banks untouched); it overrides any handshake in that cycle.
//   - Reset or flush mid-block: the partial block is discarded and never emitted.
//   - Changes to shift_en mid-block are ignored.
//   - in_data is ignored when in_ready = 0.
// STRUCTURE
//  Package aes_pkg holds:
//   - AES_STATE_BYTES = 16 and typedef logic [7:0] aes_byte_t.
//   - typedef logic [3:0] aes_idx_t.
//   - function shiftrows_src(aes_idx_t k, bit inv) returning aes_idx_t.
//  Sub-module aes_state_bank: 16x8 register file with one synchronous write port
//  and one combinational read port. It is instantiated twice (ping-pong).
//  Top level holds the pointers, full/mode flags, permutation and output gating.
// TESTING
//  1. Reset, then block 0x00..0x0F, shift_en=1, INVERSE=0, out_ready=1
//     -> out_data = 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B; out_last at the 16th byte.
//  2. Same stimulus with INVERSE=1
//     -> 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
//  3. shift_en=0, block 0x10..0x1F -> output 0x10..0x1F in order; out_idx 0..15.
//  4. 3 back-to-back blocks, in_valid=out_ready=1
//     -> in_ready never drops; 48 outputs, each block correctly permuted.
//  5. out_ready=0 while 2 blocks are written -> in_ready falls after byte 32;
//     raising out_ready drains block 1 then block 2.
//  6. Flush (or rst_n=0) after 7 bytes, then a fresh block
//     -> none of the 7 bytes ever appear; the new block is emitted correctly.

Source files
------------

// File: rtl/aes_shiftrows_byte_buffer_pkg.sv
// Shared types and the ShiftRows source-index helper for the byte-serial AES datapath.
package aes_pkg;
  localparam int AES_STATE_BYTES = 16;

  typedef logic [7:0] aes_byte_t;
  typedef logic [3:0] aes_idx_t;

  // Output position k = {col, row} reads from {(col +/- row) mod 4, row}; 2-bit wrap is the mod 4.
  function automatic aes_idx_t shiftrows_src(aes_idx_t k, bit inv);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = k[1:0];
    col     = k[3:2];
    src_col = inv ? (col - row) : (col + row);
    return {src_col, row};
  endfunction
endpackage

// File: rtl/aes_shiftrows_byte_buffer_if.sv
// Byte-stream handshake bundle between the ShiftRows buffer and its producer/consumer.
interface aes_shiftrows_byte_buffer_if;
  import aes_pkg::*;

  logic      shift_en;
  logic      in_valid;
  logic      in_ready;
  aes_byte_t in_data;
  logic      out_valid;
  logic      out_ready;
  aes_byte_t out_data;
  aes_idx_t  out_idx;
  logic      out_last;

  modport master (
    output shift_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  shift_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/aes_shiftrows_byte_buffer_bank.sv
// One AES state held as a 16x8 register file: synchronous write, combinational read.
module aes_state_bank
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  aes_idx_t  waddr,
  input  aes_byte_t wdata,
  input  aes_idx_t  raddr,
  output aes_byte_t rdata
);
  aes_byte_t mem [AES_STATE_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/aes_shiftrows_byte_buffer.sv
// Ping-pong byte buffer applying ShiftRows (or InvShiftRows) to column-major AES states.
module aes_shiftrows_byte_buffer
  import aes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = AES_STATE_BYTES,
  parameter bit INVERSE   = 1'b0
) (
  input logic                          clk,
  input logic                          rst_n,
  input logic                          flush,
  aes_shiftrows_byte_buffer_if.slave   bus
);
  localparam aes_idx_t LAST_IDX = aes_idx_t'(NUM_BYTES - 1);

  logic       wr_bank_reg, wr_bank_next;
  logic       rd_bank_reg, rd_bank_next;
  aes_idx_t   wr_idx_reg,  wr_idx_next;
  aes_idx_t   rd_idx_reg,  rd_idx_next;
  logic [1:0] full_reg,    full_next;
  logic [1:0] mode_reg,    mode_next;

  logic              in_ready;
  logic              out_valid;
  logic              wr_fire;
  logic              rd_fire;
  aes_idx_t          src_idx;
  aes_byte_t         bank_rdata [2];
  logic [DATA_W-1:0] out_byte;

  assign in_ready  = ~full_reg[wr_bank_reg];
  assign out_valid = full_reg[rd_bank_reg];
  // Bank writes are suppressed during reset and flush so a clear never leaves a stray byte.
  assign wr_fire   = bus.in_valid & in_ready & ~flush & rst_n;
  assign rd_fire   = out_valid & bus.out_ready & ~flush & rst_n;
  assign src_idx   = mode_reg[rd_bank_reg] ? shiftrows_src(rd_idx_reg, INVERSE) : rd_idx_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    aes_state_bank u_bank (
      .clk   (clk),
      .we    (wr_fire & (wr_bank_reg == 1'(gi))),
      .waddr (wr_idx_reg),
      .wdata (bus.in_data),
      .raddr (src_idx),
      .rdata (bank_rdata[gi])
    );
  end

  always_comb begin
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    wr_idx_next  = wr_idx_reg;
    rd_idx_next  = rd_idx_reg;
    full_next    = full_reg;
    mode_next    = mode_reg;
    if (flush) begin
      wr_bank_next = 1'b0;
      rd_bank_next = 1'b0;
      wr_idx_next  = '0;
      rd_idx_next  = '0;
      full_next    = '0;
      mode_next    = '0;
    end else begin
      if (wr_fire) begin
        if (wr_idx_reg == '0) begin
          mode_next[wr_bank_reg] = bus.shift_en;
        end
        if (wr_idx_reg == LAST_IDX) begin
          wr_idx_next            = '0;
          full_next[wr_bank_reg] = 1'b1;
          wr_bank_next           = ~wr_bank_reg;
        end else begin
          wr_idx_next = wr_idx_reg + 4'd1;
        end
      end
      // The read bank is always full and the write bank never is, so these never collide.
      if (rd_fire) begin
        if (rd_idx_reg == LAST_IDX) begin
          rd_idx_next            = '0;
          full_next[rd_bank_reg] = 1'b0;
          rd_bank_next           = ~rd_bank_reg;
        end else begin
          rd_idx_next = rd_idx_reg + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      full_reg    <= '0;
      mode_reg    <= '0;
    end else begin
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      wr_idx_reg  <= wr_idx_next;
      rd_idx_reg  <= rd_idx_next;
      full_reg    <= full_next;
      mode_reg    <= mode_next;
    end
  end

  assign out_byte      = out_valid ? bank_rdata[rd_bank_reg] : '0;
  assign bus.out_data  = out_byte;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = rd_idx_reg;
  assign bus.out_last  = out_valid & (rd_idx_reg == LAST_IDX);
endmodule

// File: tb/tb_aes_shiftrows_byte_buffer.sv
// Drives identical byte streams into a ShiftRows and an InvShiftRows buffer and checks both
// against a block-level queue model.
module tb_aes_shiftrows_byte_buffer;
  import aes_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  aes_shiftrows_byte_buffer_if bus_fwd ();
  aes_shiftrows_byte_buffer_if bus_inv ();

  aes_shiftrows_byte_buffer #(.DATA_W(8), .NUM_BYTES(16), .INVERSE(1'b0)) u_dut_fwd (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_fwd)
  );

  aes_shiftrows_byte_buffer #(.DATA_W(8), .NUM_BYTES(16), .INVERSE(1'b1)) u_dut_inv (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
  } exp_t;

  exp_t       exp_fwd [$];
  exp_t       exp_inv [$];
  logic [7:0] src_q   [$];
  bit         sh_q    [$];
  logic [7:0] part_q  [$];
  bit         part_shift;
  int         valid_pct = 100;
  int         ready_pct = 100;
  int         errors    = 0;
  int         checks    = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Where ShiftRows output k comes from, straight from the row-rotation rule.
  function automatic int ref_src(int k, bit shift, bit inv);
    int r;
    int c;
    r = k % 4;
    c = k / 4;
    if (!shift) return k;
    if (inv) return 4 * ((c - r + 4) % 4) + r;
    return 4 * ((c + r) % 4) + r;
  endfunction

  task automatic retire_block();
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.idx  = 4'(k);
      e.data = part_q[ref_src(k, part_shift, 1'b0)];
      exp_fwd.push_back(e);
      e.data = part_q[ref_src(k, part_shift, 1'b1)];
      exp_inv.push_back(e);
    end
    part_q.delete();
  endtask

  task automatic add_block(int base, bit shift, int len);
    for (int i = 0; i < len; i++) begin
      src_q.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
      sh_q.push_back(i == 0 ? shift : 1'($urandom));
    end
  endtask

  task automatic check_port(string nm, exp_t q[$], int nfull, logic rdy, logic v,
                            logic [7:0] d, logic [3:0] idx, logic last);
    check_val({nm, ".in_ready"}, 32'(rdy), 32'(nfull < 2));
    check_val({nm, ".out_valid"}, 32'(v), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_val({nm, ".out_data"}, 32'(d), 32'(q[0].data));
      check_val({nm, ".out_idx"}, 32'(idx), 32'(q[0].idx));
      check_val({nm, ".out_last"}, 32'(last), 32'(q[0].idx == 4'd15));
    end else begin
      check_val({nm, ".out_data_idle"}, 32'(d), 32'd0);
      check_val({nm, ".out_idx_idle"}, 32'(idx), 32'd0);
      check_val({nm, ".out_last_idle"}, 32'(last), 32'd0);
    end
  endtask

  // One clock: drive just after the rising edge, check on the falling edge, advance the model.
  task automatic step();
    bit         iv;
    bit         orr;
    bit         sh;
    bit         acc;
    bit         cons;
    logic [7:0] d;
    int         nfull;
    iv  = (src_q.size() > 0) && (int'($urandom_range(99)) < valid_pct);
    d   = iv ? src_q[0] : 8'($urandom);
    sh  = iv ? sh_q[0] : 1'($urandom);
    orr = int'($urandom_range(99)) < ready_pct;
    bus_fwd.in_valid = iv;  bus_fwd.in_data = d;  bus_fwd.shift_en = sh;  bus_fwd.out_ready = orr;
    bus_inv.in_valid = iv;  bus_inv.in_data = d;  bus_inv.shift_en = sh;  bus_inv.out_ready = orr;
    @(negedge clk);
    nfull = (exp_fwd.size() + 15) / 16;
    check_port("fwd", exp_fwd, nfull, bus_fwd.in_ready, bus_fwd.out_valid,
               bus_fwd.out_data, bus_fwd.out_idx, bus_fwd.out_last);
    check_port("inv", exp_inv, nfull, bus_inv.in_ready, bus_inv.out_valid,
               bus_inv.out_data, bus_inv.out_idx, bus_inv.out_last);
    acc  = iv && (nfull < 2) && !flush && rst_n;
    cons = (exp_fwd.size() > 0) && orr && !flush && rst_n;
    @(posedge clk);
    if (!rst_n || flush) begin
      part_q.delete();
      exp_fwd.delete();
      exp_inv.delete();
    end else begin
      if (cons) begin
        void'(exp_fwd.pop_front());
        void'(exp_inv.pop_front());
      end
      if (acc) begin
        if (part_q.size() == 0) part_shift = sh;
        part_q.push_back(d);
        void'(src_q.pop_front());
        void'(sh_q.pop_front());
        if (part_q.size() == 16) retire_block();
      end
    end
    #1;
  endtask

  task automatic run_n(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_idle(int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_fwd.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_val("drain_within_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_fwd.in_valid = 1'b0; bus_fwd.in_data = '0; bus_fwd.shift_en = 1'b0; bus_fwd.out_ready = 1'b0;
    bus_inv.in_valid = 1'b0; bus_inv.in_data = '0; bus_inv.shift_en = 1'b0; bus_inv.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_n(2);

    // Counting blocks, permuted then passthrough.
    add_block(8'h00, 1'b1, 16);
    run_idle(100);
    add_block(8'h10, 1'b0, 16);
    run_idle(100);

    // Back-to-back blocks at full rate.
    for (int b = 0; b < 3; b++) add_block(-1, 1'(b != 1), 16);
    run_idle(200);

    // Consumer stalled: both banks fill, then drain in order.
    ready_pct = 0;
    for (int b = 0; b < 3; b++) add_block(-1, 1'b1, 16);
    run_n(40);
    ready_pct = 100;
    run_idle(200);

    // Abort a partial block by flush, then by reset.
    add_block(8'hA0, 1'b1, 7);
    run_n(7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    add_block(8'h30, 1'b1, 16);
    run_idle(100);
    add_block(8'hB0, 1'b0, 7);
    run_n(7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    add_block(8'h40, 1'b1, 16);
    run_idle(100);

    // Flush while a full block is waiting for the consumer.
    ready_pct = 0;
    add_block(-1, 1'b1, 20);
    run_n(24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    ready_pct = 100;
    src_q.delete();
    sh_q.delete();
    add_block(8'h50, 1'b1, 16);
    run_idle(100);

    // Random traffic with occasional flushes.
    valid_pct = 70;
    ready_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() < 32) add_block(-1, 1'($urandom), 16);
      flush = ($urandom_range(299) == 0);
      step();
      flush = 1'b0;
    end
    run_idle(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
